// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter. It inhibits the bus by holding the clock
//   low, issues the request-to-send (start bit), then shifts out eight data
//   bits LSB first, an odd parity bit and a stop bit on the falling edges of
//   the device clock. It then checks the device acknowledge and waits for the
//   bus to go idle. A timeout guards against a device that never clocks or
//   never acknowledges.
//
// Ports
//   Clk          system clock, all state on the rising edge
//   Reset_n      asynchronous active-low reset
//   PS2_Clk      raw keyboard clock pad input
//   PS2_Data     raw keyboard data pad input
//   PS2_Clk_Oe   1 = pad pulls PS2_Clk low, 0 = released
//   PS2_Data_Oe  1 = pad pulls PS2_Data low, 0 = released
//   Tx_Data      byte to transmit
//   Tx_Start     one-cycle request, accepted only while Tx_Busy = 0
//   Tx_Busy      transaction in progress
//   Tx_Done      one-cycle pulse at the end of every accepted transaction
//   Tx_Err       1 = no acknowledge or timeout; valid from Tx_Done, cleared on accept

module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       PS2_Clk,
   input  logic       PS2_Data,
   output logic       PS2_Clk_Oe,
   output logic       PS2_Data_Oe,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_Start,
   output logic       Tx_Busy,
   output logic       Tx_Done,
   output logic       Tx_Err
);

   // Counters only ever reach terminal-1, so $clog2(N) bits never wrap.
   localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t state, state_next;

   logic [7:0]       clk_shift;
   logic             clk_f;
   logic             clk_f_d;
   logic             fall;
   logic             dat_meta;
   logic             dat_s;

   logic [7:0]       tx_byte;
   logic             parity;
   logic [9:0]       frame;
   logic [3:0]       bit_idx;
   logic             bit_oe;
   logic [INH_W-1:0] inh_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic             accept;
   logic             inh_last;
   logic             timeout;
   logic             in_timed;

   // ---------------------------------------------------------------
   // Input conditioning: clock glitch filter and data resynchroniser
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         clk_shift <= '1;
         clk_f     <= 1'b1;
         clk_f_d   <= 1'b1;
         dat_meta  <= 1'b1;
         dat_s     <= 1'b1;
      end else begin
         clk_shift <= {clk_shift[6:0], PS2_Clk};
         if (clk_shift == '1) begin
            clk_f <= 1'b1;
         end else if (clk_shift == '0) begin
            clk_f <= 1'b0;
         end
         clk_f_d   <= clk_f;
         dat_meta  <= PS2_Data;
         dat_s     <= dat_meta;
      end
   end

   assign fall = clk_f_d & ~clk_f;

   // Bits presented on successive falls: data LSB first, parity, stop.
   assign frame    = {1'b1, parity, tx_byte};
   assign accept   = (state == S_IDLE) && Tx_Start;
   assign inh_last = (inh_cnt == INH_LAST);
   assign in_timed = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
   assign timeout  = in_timed && (to_cnt == TO_LAST);

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (Tx_Start) state_next = S_INHIBIT;
         end
         S_INHIBIT: begin
            if (inh_last) state_next = S_REQ;
         end
         S_REQ: begin
            state_next = S_SEND;
         end
         S_SEND: begin
            // The fall that presents the stop bit also moves to ACK.
            if (timeout)                      state_next = S_IDLE;
            else if (fall && bit_idx == 4'd9) state_next = S_ACK;
         end
         S_ACK: begin
            if (timeout)   state_next = S_IDLE;
            else if (fall) state_next = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (timeout || (clk_f && dat_s)) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs (decoded from state so reset releases the pads at once)
   // ---------------------------------------------------------------
   always_comb begin
      PS2_Clk_Oe  = 1'b0;
      PS2_Data_Oe = 1'b0;
      unique case (state)
         S_INHIBIT: PS2_Clk_Oe  = 1'b1;
         S_REQ: begin
            PS2_Clk_Oe  = 1'b1;
            PS2_Data_Oe = 1'b1;
         end
         S_SEND:    PS2_Data_Oe = bit_oe;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath: byte latch, counters, bit sequencing, status flags
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         tx_byte <= '0;
         parity  <= 1'b0;
         bit_idx <= '0;
         bit_oe  <= 1'b0;
         inh_cnt <= '0;
         to_cnt  <= '0;
         Tx_Busy <= 1'b0;
         Tx_Done <= 1'b0;
         Tx_Err  <= 1'b0;
      end else begin
         Tx_Done <= 1'b0;

         if (accept) begin
            tx_byte <= Tx_Data;
            parity  <= ~^Tx_Data;
            Tx_Err  <= 1'b0;
            Tx_Busy <= 1'b1;
            inh_cnt <= '0;
         end

         if (state == S_INHIBIT && !inh_last) begin
            inh_cnt <= inh_cnt + 1'b1;
         end

         if (state == S_REQ) begin
            bit_idx <= '0;
            bit_oe  <= 1'b1;       // keep the start bit driven until the first fall
            to_cnt  <= '0;
         end

         if (in_timed) begin
            if (timeout) begin
               Tx_Err  <= 1'b1;
               Tx_Done <= 1'b1;
               Tx_Busy <= 1'b0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
               if (state == S_SEND && fall) begin
                  bit_oe  <= ~frame[bit_idx];
                  bit_idx <= bit_idx + 4'd1;
               end
               if (state == S_ACK && fall && dat_s) begin
                  Tx_Err <= 1'b1;
               end
               if (state == S_WAIT_IDLE && clk_f && dat_s) begin
                  Tx_Done <= 1'b1;
                  Tx_Busy <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Directed bench for ps2_host_tx with an open-drain bus and a simple device
//   model that clocks the frame, records what the host presents on each low
//   clock phase and optionally acknowledges. Parameters are scaled down so the
//   run stays short; the device clock half period is still well above the
//   8-cycle clock filter.

module tb_ps2_host_tx;

   localparam int unsigned INH = 50;
   localparam int unsigned TO  = 3000;
   localparam int unsigned H   = 40;   // device clock half period in Clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk;
   logic       ps2_data;
   logic       clk_oe;
   logic       data_oe;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       busy;
   logic       done;
   logic       err;

   // Open-drain bus with pull-ups: either side may pull a line low.
   assign ps2_clk  = dev_clk & ~clk_oe;
   assign ps2_data = dev_data & ~data_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .Clk        (clk),
      .Reset_n    (rst_n),
      .PS2_Clk    (ps2_clk),
      .PS2_Data   (ps2_data),
      .PS2_Clk_Oe (clk_oe),
      .PS2_Data_Oe(data_oe),
      .Tx_Data    (tx_data),
      .Tx_Start   (tx_start),
      .Tx_Busy    (busy),
      .Tx_Done    (done),
      .Tx_Err     (err)
   );

   int   tests = 0;
   int   failed = 0;
   int   done_total = 0;
   logic err_at_done = 1'b0;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_total  <= done_total + 1;
         err_at_done <= err;
      end
   end

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         inject;
      logic [9:0] exp_oe;   // index 0..7 data Oe, 8 parity Oe, 9 stop Oe
      bit         exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Request a transfer, then measure the inhibit and request phases.
   // Returns at the first sample with the clock released.
   task automatic accept_and_inhibit(input logic [7:0] b);
      int inh_n = 0;
      int req_n = 0;
      bit released = 0;
      @(negedge clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("busy_on_accept", 32'(busy), 32'd1);
      check("err_cleared_on_accept", 32'(err), 32'd0);
      for (int i = 0; i < int'(INH) + 100; i++) begin
         if (clk_oe && !data_oe)      inh_n++;
         else if (clk_oe && data_oe)  req_n++;
         else begin
            released = 1;
            break;
         end
         @(negedge clk);
      end
      check("clock_released", 32'(released), 32'd1);
      check("inhibit_len", 32'(inh_n), 32'(INH));
      check("req_len", 32'(req_n), 32'd1);
      check("start_bit_held", 32'(data_oe), 32'd1);
   endtask

   task automatic run_xfer(input logic [7:0] b, input bit ack, input bit inject,
                           input logic [9:0] exp_oe, input bit exp_err);
      int         snap;
      logic [9:0] oe_bits = '0;
      snap = done_total;
      accept_and_inhibit(b);
      repeat (H) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         repeat (H / 2) @(negedge clk);
         if (k <= 10) oe_bits[k-1] = data_oe;
         if (inject && k == 5) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
         end
         repeat (H / 2) @(negedge clk);
         dev_clk = 1'b1;
         if (k == 10 && ack) dev_data = 1'b0;
         repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
      for (int i = 0; i < 100 && done_total == snap; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      check("frame_oe_bits", 32'(oe_bits), 32'(exp_oe));
      check("done_count", 32'(done_total - snap), 32'd1);
      check("err_at_done", 32'(err_at_done), 32'(exp_err));
      check("err_level_held", 32'(err), 32'(exp_err));
      check("busy_after_done", 32'(busy), 32'd0);
      check("lines_released", 32'({clk_oe, data_oe}), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'hED, 1'b1, 1'b0, 10'h012, 1'b0};
      vecs[1] = '{8'h01, 1'b1, 1'b0, 10'h1FE, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 10'h000, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 10'h0FF, 1'b0};
      vecs[4] = '{8'h3C, 1'b1, 1'b1, 10'h0C3, 1'b0};   // 0x55 request during SEND is ignored
      vecs[5] = '{8'hAA, 1'b0, 1'b0, 10'h055, 1'b1};   // device never acknowledges
      vecs[6] = '{8'h12, 1'b1, 1'b0, 10'h0ED, 1'b0};   // accept clears the previous error

      // Reset state
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_clk_oe", 32'(clk_oe), 32'd0);
      check("rst_data_oe", 32'(data_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_xfer(vecs[i].data, vecs[i].ack, vecs[i].inject, vecs[i].exp_oe, vecs[i].exp_err);
      end

      // Device never clocks: timeout counted from clock release
      begin
         int snap;
         int n;
         snap = done_total;
         accept_and_inhibit(8'h5A);
         n = 0;
         while (n < int'(TO) + 100) begin
            @(negedge clk);
            n++;
            if (done) break;
         end
         check("timeout_len", 32'(n), 32'(TO));
         check("timeout_err", 32'(err), 32'd1);
         check("timeout_lines", 32'({clk_oe, data_oe}), 32'd0);
         repeat (5) @(negedge clk);
         check("timeout_done_count", 32'(done_total - snap), 32'd1);
      end

      // Reset while bit index 4 is in flight
      begin
         int snap;
         snap = done_total;
         accept_and_inhibit(8'h77);
         repeat (H) @(negedge clk);
         for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            repeat (H / 2) @(negedge clk);
            if (k < 4) begin
               repeat (H / 2) @(negedge clk);
               dev_clk = 1'b1;
               repeat (H) @(negedge clk);
            end
         end
         check("pre_reset_data_oe", 32'(data_oe), 32'd1);   // bit 3 of 0x77 is 0
         #3;
         rst_n = 1'b0;
         #1;
         check("midrst_lines", 32'({clk_oe, data_oe}), 32'd0);
         check("midrst_busy", 32'(busy), 32'd0);
         dev_clk  = 1'b1;
         dev_data = 1'b1;
         repeat (5) @(negedge clk);
         rst_n = 1'b1;
         repeat (20) @(negedge clk);
         check("midrst_no_done", 32'(done_total - snap), 32'd0);
         run_xfer(8'hF4, 1'b1, 1'b0, 10'h10B, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
